knn_seq: RTL and testbench
==========================

# knn_seq

Sequencer that drives the KNN neighbour-selection core across a stored training set for one test point. On a software start it clears the core's neighbour list, then walks the training memory one point at a time. Each point gets a one-cycle memory read, followed by a valid/ready handoff into the core. It reports progress and completion to the KNN register file, and it sits between the software registers, the training-point memory and the knn_core datapath.

## Interface
- ADDR_W, 8, training memory address width; maximum set size is 2^ADDR_W points
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to process the set; ignored while busy
- abort  in  1  cancels the run in progress; ignored in IDLE
- n_train  in  ADDR_W+1  number of training points; sampled only on an accepted start
- mem_en  out  1  training memory read enable; read data is valid the cycle after
- mem_addr  out  ADDR_W  training point index being read
- core_clear  out  1  one-cycle pulse that empties the core neighbour list
- core_valid  out  1  the training point on the memory data bus is presented to the core
- core_ready  in  1  core accepts the point when core_valid & core_ready
- busy  out  1  high from the cycle after an accepted start until the last handshake
- done  out  1  level; set on completion, cleared by the next accepted start, abort or rst
- count  out  ADDR_W+1  number of points accepted by the core in the current or last run

## Operation
- FSM states: IDLE, CLEAR, READ, ISSUE.
- IDLE
  - start & n_train!=0: latch n_train, clear idx and count, clear done, go to CLEAR.
  - start & n_train==0: done=1 next cycle, count=0, no core_clear, no memory read, stay in IDLE.
- CLEAR: core_clear=1 for exactly one cycle, then READ.
- READ: mem_en=1, mem_addr=idx, then ISSUE.
- ISSUE
  - core_valid=1 and mem_addr held at idx; mem_en=0, so the memory output stays stable.
  - Remain in ISSUE while core_ready=0; core_valid must not drop.
  - On handshake: count+1.
  - If idx==n_lat-1, go to IDLE with done=1.
  - Otherwise idx+1 and go to READ.
- abort in CLEAR/READ/ISSUE: next state IDLE; busy=0, done stays 0, count keeps its value, no core_valid that cycle.
  - A handshake in the same cycle as abort still increments count.
- start while busy has no effect; n_lat never changes mid-run.
- idx is ADDR_W bits; n_train=2^ADDR_W addresses 0..2^ADDR_W-1, with no wrap before the last point.
- n_train values above 2^ADDR_W are clamped to 2^ADDR_W.
- busy is a function of state: high exactly when state != IDLE.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from start/core_ready to any output except through state.
- Reset values: state IDLE; mem_en, mem_addr, core_clear, core_valid, busy, done and count all 0.
- rst has priority over abort, and abort has priority over start and handshake state transitions.
- Accepted start sampled at edge E0:
  - CLEAR during cycle 1
  - READ during cycle 2
  - ISSUE during cycle 3
- With core_ready tied high, point k is issued in cycle 3+2k. The last point is issued in cycle 1+2N, and done=1 and busy=0 from cycle 2+2N.
- Each core_ready=0 cycle in ISSUE adds one cycle of latency.
- done and busy are never both 1.

## Test plan
- Reset then idle: rst for 2 cycles, all inputs 0 → every output 0; mem_en never asserts.
- Basic run, ADDR_W=8, n_train=3, core_ready=1:
  - core_clear in cycle 1
  - mem_addr 0,1,2 with core_valid in cycles 3,5,7
  - done=1 and count=3 from cycle 8
  - busy high in cycles 1-7
- Backpressure, n_train=2, core_ready low for 3 cycles on point 0:
  - core_valid and mem_addr=0 held 4 cycles
  - exactly 2 handshakes; done at cycle 9
- Zero and full size:
  - n_train=0 → done=1 in cycle 1, no core_clear or mem_en.
  - n_train=256 → addresses 0..255 each read once; count=256, and no address repeats.
- Abort mid-run, n_train=10, abort in cycle 6:
  - IDLE in cycle 7, busy=0, done=0, count=2
  - a following start with n_train=1 completes with count=1
- Ignored start and reset mid-run:
  - start pulsed in cycle 4 of a run with n_train=5 → no restart; count=5 at done.
  - rst in cycle 5 → all outputs 0 next cycle.

Source files
------------

// File: rtl/knn_seq.sv
// Walks the training-point memory for one test point and hands each point to knn_core
// through a valid/ready handshake, reporting progress and completion to the register file.
module knn_seq #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   n_train,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              core_clear,
    output logic              core_valid,
    input  logic              core_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        READ,
        ISSUE
    } state_t;

    localparam logic [ADDR_W:0]   MAX_N   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   nLat_q, nLat_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              lastPoint;

    // idx is one bit narrower than nLat so a full 2^ADDR_W set ends on idx = all ones.
    assign lastPoint = ({1'b0, idx_q} == (nLat_q - CNT_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            nLat_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nLat_q  <= nLat_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nLat_d  = nLat_q;
        count_d = count_q;
        done_d  = done_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = '0;
                    if (n_train == '0) begin
                        done_d = 1'b1;
                    end else begin
                        nLat_d  = (n_train > MAX_N) ? MAX_N : n_train;
                        idx_d   = '0;
                        done_d  = 1'b0;
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: state_d = READ;
            READ:  state_d = ISSUE;
            ISSUE: begin
                if (core_ready) begin
                    count_d = count_q + CNT_ONE;
                    if (lastPoint) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides the transition but keeps any handshake already counted this cycle.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    assign mem_en     = (state_q == READ);
    assign mem_addr   = idx_q;
    assign core_clear = (state_q == CLEAR);
    assign core_valid = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign count      = count_q;

endmodule

// File: tb/tb_knn_seq.sv
// Directed self-checking bench for knn_seq: reset, plain runs, backpressure, zero/full size,
// clamping, abort, ignored start and reset mid-run, each against hand-derived cycle timing.
module tb_knn_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [8:0] nTrain;
    logic       memEn;
    logic [7:0] memAddr;
    logic       coreClear;
    logic       coreValid;
    logic       coreReady;
    logic       busy;
    logic       done;
    logic [8:0] count;

    int compared   = 0;
    int mismatched = 0;

    knn_seq #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .n_train   (nTrain),
        .mem_en    (memEn),
        .mem_addr  (memAddr),
        .core_clear(coreClear),
        .core_valid(coreValid),
        .core_ready(coreReady),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for the edge E0; on return the bench sits in cycle 1.
    task automatic applyStimulus(input int n);
        nTrain = n[8:0];
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Run of n points with core_ready high, checked cycle by cycle against the 2-cycle cadence.
    task automatic runPlain(input int n);
        coreReady = 1'b1;
        applyStimulus(n);
        for (int c = 1; c <= 2 * n + 2; c++) begin
            checkOutput($sformatf("clear c%0d", c), int'(coreClear), int'(c == 1));
            checkOutput($sformatf("memEn c%0d", c), int'(memEn),
                        int'(c >= 2 && c <= 2 * n && (c % 2 == 0)));
            checkOutput($sformatf("valid c%0d", c), int'(coreValid),
                        int'(c >= 3 && c <= 2 * n + 1 && (c % 2 == 1)));
            checkOutput($sformatf("busy c%0d", c), int'(busy), int'(c <= 2 * n + 1));
            checkOutput($sformatf("done c%0d", c), int'(done), int'(c == 2 * n + 2));
            if (c >= 2 && c <= 2 * n && (c % 2 == 0))
                checkOutput($sformatf("rdAddr c%0d", c), int'(memAddr), (c - 2) / 2);
            if (c >= 3 && c <= 2 * n + 1 && (c % 2 == 1))
                checkOutput($sformatf("isAddr c%0d", c), int'(memAddr), (c - 3) / 2);
            if (c == 2 * n + 2)
                checkOutput("plain count", int'(count), n);
            if (c < 2 * n + 2)
                tick();
        end
    endtask

    // Large run: every read must be the next sequential address, bounded in cycles.
    task automatic runFull(input int nIn, input int nExp);
        int reads = 0;
        int cyc   = 0;
        coreReady = 1'b1;
        applyStimulus(nIn);
        while (!done && cyc < 2 * nExp + 10) begin
            if (memEn) begin
                checkOutput("full addr order", int'(memAddr), reads % 256);
                reads++;
            end
            tick();
            cyc++;
        end
        checkOutput("full finished", int'(done), 1);
        checkOutput("full reads", reads, nExp);
        checkOutput("full count", int'(count), nExp);
        checkOutput("full cycles", cyc + 1, 2 * nExp + 2);
    endtask

    initial begin
        int hs;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        nTrain    = '0;
        coreReady = 1'b0;

        // Reset and idle
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst memEn", int'(memEn), 0);
            checkOutput("rst clear", int'(coreClear), 0);
            checkOutput("rst valid", int'(coreValid), 0);
            tick();
        end
        checkOutput("rst addr", int'(memAddr), 0);
        checkOutput("rst busy", int'(busy), 0);
        checkOutput("rst done", int'(done), 0);
        checkOutput("rst count", int'(count), 0);

        // Zero-size set
        applyStimulus(0);
        for (int c = 1; c <= 3; c++) begin
            checkOutput("zero done", int'(done), 1);
            checkOutput("zero busy", int'(busy), 0);
            checkOutput("zero clear", int'(coreClear), 0);
            checkOutput("zero memEn", int'(memEn), 0);
            checkOutput("zero count", int'(count), 0);
            tick();
        end

        // Basic runs
        runPlain(3);
        runPlain(2);

        // Backpressure: core_ready low in cycles 3..5 on point 0
        coreReady = 1'b0;
        applyStimulus(2);
        hs = 0;
        for (int c = 1; c <= 9; c++) begin
            coreReady = (c >= 6);
            if (c >= 3 && c <= 6) begin
                checkOutput($sformatf("bp valid c%0d", c), int'(coreValid), 1);
                checkOutput($sformatf("bp addr c%0d", c), int'(memAddr), 0);
            end
            checkOutput($sformatf("bp done c%0d", c), int'(done), int'(c == 9));
            if (coreValid && coreReady) hs++;
            if (c < 9) tick();
        end
        checkOutput("bp handshakes", hs, 2);
        checkOutput("bp count", int'(count), 2);

        // Abort in cycle 6 of a 10-point run
        coreReady = 1'b1;
        applyStimulus(10);
        for (int c = 1; c < 6; c++) tick();
        checkOutput("abort pre busy", int'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort count", int'(count), 2);
        checkOutput("abort valid", int'(coreValid), 0);
        checkOutput("abort memEn", int'(memEn), 0);
        tick();
        checkOutput("abort idle", int'(busy), 0);
        runPlain(1);

        // Start while busy is ignored
        applyStimulus(5);
        for (int c = 1; c < 4; c++) tick();
        nTrain = 9'd2;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        checkOutput("ign clear c5", int'(coreClear), 0);
        checkOutput("ign busy c5", int'(busy), 1);
        for (int c = 5; c < 11; c++) tick();
        checkOutput("ign done c11", int'(done), 0);
        tick();
        checkOutput("ign done c12", int'(done), 1);
        checkOutput("ign count", int'(count), 5);

        // Reset mid-run
        applyStimulus(5);
        for (int c = 1; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mrst memEn", int'(memEn), 0);
        checkOutput("mrst addr", int'(memAddr), 0);
        checkOutput("mrst clear", int'(coreClear), 0);
        checkOutput("mrst valid", int'(coreValid), 0);
        checkOutput("mrst busy", int'(busy), 0);
        checkOutput("mrst done", int'(done), 0);
        checkOutput("mrst count", int'(count), 0);

        // Full-size and clamped sets
        runFull(256, 256);
        runFull(300, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
